// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef logic [4:0]  regid_t;
    typedef logic [31:0] word_t;

    localparam regid_t R0 = 5'd0;

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        DMEM_WAIT,
        IMEM_WAIT
    } pc_state_t;

    // Wide enough for LOAD_USE_CYCLES-1 with LOAD_USE_CYCLES up to 3.
    localparam int LU_CNT_W = 2;
    typedef logic [LU_CNT_W-1:0] lu_cnt_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard check between the Decode sources and the load in Execute.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  regid_t d_src_a_i,
    input  regid_t d_src_b_i,
    input  logic   d_src_a_ok_i,
    input  logic   d_src_b_ok_i,
    input  regid_t e_dst_m_i,
    output logic   load_use_o
);

    logic hit_a, hit_b;

    assign hit_a      = d_src_a_ok_i && (d_src_a_i == e_dst_m_i);
    assign hit_b      = d_src_b_ok_i && (d_src_b_i == e_dst_m_i);
    assign load_use_o = (e_dst_m_i != R0) && (hit_a || hit_b);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/redirect controller.
// Optional stall-cycle counter port enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  regid_t d_src_a,
    input  regid_t d_src_b,
    input  logic   d_src_a_ok,
    input  logic   d_src_b_ok,
    input  regid_t e_dst_m,
    input  logic   d_br_taken,
    input  word_t  d_br_target,
    input  logic   i_busy,
    input  logic   d_busy,
    output logic   stall_f,
    output logic   stall_d,
    output logic   stall_e,
    output logic   stall_m,
    output logic   bubble_e,
    output logic   bubble_w,
    output logic   redir_valid,
    output word_t  redir_pc
`ifdef PIPE_CTRL_PERF_EN
    ,
    output word_t  perf_stall_cnt
`endif
);

    localparam lu_cnt_t LU_INIT = lu_cnt_t'(LOAD_USE_CYCLES - 1);

    pc_state_t state_q, state_d;
    lu_cnt_t   cnt_q, cnt_d;
    logic      pend_q, pend_d;
    word_t     pc_q, pc_d;

    logic lu_hazard, run_eval;
    logic sf, sd, se, sm, be, bw;

    hazard_detect u_hazard (
        .d_src_a_i    (d_src_a),
        .d_src_b_i    (d_src_b),
        .d_src_a_ok_i (d_src_a_ok),
        .d_src_b_ok_i (d_src_b_ok),
        .e_dst_m_i    (e_dst_m),
        .load_use_o   (lu_hazard)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pc_q    <= pc_d;
        end
    end

    // Any cycle that falls back to RUN re-evaluates the RUN rules, so a hazard
    // or fetch miss present on the resume cycle is never skipped.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        {sf, sd, se, sm, be, bw} = '0;
        run_eval = 1'b0;
        if (d_busy) begin
            {sf, sd, se, sm, be, bw} = 6'b111101;
            state_d = DMEM_WAIT;
        end else begin
            case (state_q)
                LU_STALL, DMEM_WAIT: begin
                    // A frozen count resumes right on the DMEM exit cycle.
                    if (cnt_q != '0) begin
                        {sf, sd, be} = 3'b111;
                        cnt_d   = cnt_q - lu_cnt_t'(1);
                        state_d = LU_STALL;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                IMEM_WAIT: begin
                    if (i_busy) {sf, sd, be} = 3'b111;
                    else        run_eval = 1'b1;
                end
                default: run_eval = 1'b1;
            endcase
            if (run_eval) begin
                state_d = RUN;
                cnt_d   = '0;
                if (lu_hazard) begin
                    {sf, sd, be} = 3'b111;
                    state_d = LU_STALL;
                    cnt_d   = LU_INIT;
                end else if (i_busy) begin
                    {sf, sd, be} = 3'b111;
                    state_d = IMEM_WAIT;
                end
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        pc_d   = pc_q;
        if (d_br_taken && !sd) begin
            pend_d = 1'b1;
            pc_d   = d_br_target;
        end else if (!sf) begin
            pend_d = 1'b0;
        end
    end

    assign stall_f     = sf & ~reset;
    assign stall_d     = sd & ~reset;
    assign stall_e     = se & ~reset;
    assign stall_m     = sm & ~reset;
    assign bubble_e    = be & ~reset;
    assign bubble_w    = bw & ~reset;
    assign redir_valid = pend_q;
    assign redir_pc    = pc_q;

`ifdef PIPE_CTRL_PERF_EN
    word_t perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        perf_q <= '0;
        else if (stall_f) perf_q <= perf_q + word_t'(1);
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter LOAD_USE_CYCLES, default 1, meaning the number of bubble cycles inserted per load-use hazard (legal range 1..3).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port d_src_a / d_src_b, input, 5 each, Decode source register ids.
REQ-005 SHALL have port d_src_a_ok / d_src_b_ok, input, 1 each, source actually read.
REQ-006 SHALL have port e_dst_m, input, 5, destination of the load in Execute (R0 when not a load).
REQ-007 SHALL have port d_br_taken, input, 1, Decode resolved a taken branch or jump.
REQ-008 SHALL have port d_br_target, input, 32, the redirect target.
REQ-009 SHALL have port i_busy / d_busy, input, 1 each, instruction/data memory not yet done.
REQ-010 SHALL have ports stall_f, stall_d, stall_e, stall_m, output, 1 each, hold the stage register.
REQ-011 SHALL have ports bubble_e, bubble_w, output, 1 each, load NOP into the stage register.
REQ-012 SHALL have port redir_valid, output, 1, and redir_pc, output, 32, the fetch redirect.
REQ-013 SHALL have port perf_stall_cnt, output, 32, present only under PIPE_CTRL_PERF_EN.

Function
REQ-014 SHALL implement FSM states RUN, LU_STALL, DMEM_WAIT, IMEM_WAIT.
REQ-015 Load-use SHALL be detected when e_dst_m != R0 and (d_src_a_ok and d_src_a == e_dst_m, or d_src_b_ok and d_src_b == e_dst_m).
REQ-016 In RUN on load-use SHALL assert stall_f, stall_d, bubble_e in the same cycle, enter LU_STALL, and load the bubble counter with LOAD_USE_CYCLES-1.
REQ-017 In LU_STALL SHALL keep stall_f, stall_d, bubble_e while the counter is nonzero, decrementing it; at zero SHALL return to RUN.
REQ-018 d_busy high SHALL take priority over every other condition: assert stall_f, stall_d, stall_e, stall_m, bubble_w, enter DMEM_WAIT, and freeze the LU counter.
REQ-019 DMEM_WAIT SHALL exit on the first cycle d_busy is low, to LU_STALL if the counter was frozen nonzero, otherwise to RUN.
REQ-020 i_busy high with d_busy low SHALL assert stall_f, stall_d, bubble_e, and enter IMEM_WAIT; IMEM_WAIT SHALL exit to RUN when i_busy is low.
REQ-021 A taken branch SHALL be ignored while Decode is stalled; otherwise SHALL capture d_br_target into a pending-redirect register.
REQ-022 A pending redirect SHALL drive redir_valid=1 and redir_pc on every cycle until a cycle with stall_f low, then clear.
REQ-023 A new taken branch arriving while a redirect is pending SHALL overwrite it.
REQ-024 stall_* and bubble_* SHALL be combinational from state and inputs; redir_* SHALL be registered with one-cycle latency.

Reset
REQ-025 Reset SHALL force state RUN, LU counter 0, and pending-redirect clear.
REQ-026 All stall_* outputs, bubble_* outputs, and redir_valid SHALL be 0 during and immediately after reset; redir_pc SHALL be 32'h0.
REQ-027 Reset asserted mid-stall SHALL abandon the stall without emitting a redirect.

Configuration
REQ-028 With PIPE_CTRL_PERF_EN defined, perf_stall_cnt SHALL increment, wrapping at 2^32, on every cycle stall_f is 1, and SHALL reset to 0.
REQ-029 Without PIPE_CTRL_PERF_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 The state enum, regid_t, word_t, and R0 SHALL live in the shared package.
REQ-031 Hazard detection SHALL be a sub-module hazard_detect; it SHALL be purely combinational and report the load-use condition.

Verification
REQ-032 Test load-use: e_dst_m=5, d_src_b=5, d_src_b_ok=1, LOAD_USE_CYCLES=1 -> exactly 1 cycle of stall_f, stall_d, bubble_e, then RUN.
REQ-033 Test R0 and unused source: e_dst_m=0 or d_src_a_ok=0 with ids matching -> no stall.
REQ-034 Test data wait during load-use: d_busy for 3 cycles during LU_STALL with LOAD_USE_CYCLES=3 -> all stage stalls for 3 cycles, then LU resumes with the frozen count.
REQ-035 Test redirect under i_busy: taken branch to 0xBFC00100 while i_busy=1 for 2 cycles -> redir_valid held until the stall_f-low cycle, then cleared.
REQ-036 Test reset mid-DMEM_WAIT: all outputs 0 asynchronously, redir_valid=0, and perf_stall_cnt=0 when enabled.
